// File: rtl/capi_command_arbiter_pkg.sv
// rtl/capi_command_arbiter_pkg.sv - CAPI PSL bus types, command codes, tag type and odd parity helper
package capi_command_arbiter_pkg;

  typedef logic [7:0]  tag_t;
  typedef logic [63:0] pointer_t;

  localparam logic [12:0] PSL_CMD_READ_CL_NA = 13'h0A00;
  localparam logic [12:0] PSL_CMD_READ_CL_S  = 13'h0A50;
  localparam logic [12:0] PSL_CMD_WRITE_NA   = 13'h0D00;
  localparam logic [12:0] PSL_CMD_WRITE_MI   = 13'h0D60;
  localparam logic [12:0] PSL_CMD_TOUCH_I    = 13'h0240;

  typedef struct packed {
    logic [7:0] room;
  } CommandInterfaceInput;

  typedef struct packed {
    logic        valid;
    logic [12:0] command;
    logic        command_parity;
    tag_t        tag;
    logic        tag_parity;
    logic [2:0]  abt;
    pointer_t    address;
    logic        address_parity;
    logic [15:0] context_handle;
    logic [11:0] size;
  } CommandInterfaceOutput;

  typedef struct packed {
    logic        valid;
    tag_t        tag;
    logic        tag_parity;
    logic [7:0]  response;
    logic [8:0]  credits;
  } ResponseInterface;

  // Zero-extending a narrower field leaves its parity unchanged, so one 64-bit helper covers all widths.
  function automatic logic odd_parity(input logic [63:0] data);
    return ~^data;
  endfunction

endpackage

// File: rtl/capi_command_arbiter_tag_pool.sv
// rtl/capi_command_arbiter_tag_pool.sv - capi_tag_pool: tag free bitmap, lowest-free encoder, busy count
module capi_tag_pool
  import capi_command_arbiter_pkg::*;
#(
  parameter int NUM_TAGS = 32
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                alloc,
  input  logic                free,
  input  tag_t                free_tag,
  output logic                any_free,
  output tag_t                alloc_tag,
  output logic [NUM_TAGS-1:0] busy,
  output logic [8:0]          busy_count
);

  logic                alloc_hit;
  logic [NUM_TAGS-1:0] busy_next;

  always_comb begin
    any_free  = 1'b0;
    alloc_tag = '0;
    for (int i = NUM_TAGS - 1; i >= 0; i--) begin
      if (!busy[i]) begin
        any_free  = 1'b1;
        alloc_tag = tag_t'(i);
      end
    end
  end

  assign alloc_hit = alloc && any_free;

  // Alloc picks a free tag and free targets a busy one, so both can land on the same edge.
  always_comb begin
    busy_next = busy;
    for (int i = 0; i < NUM_TAGS; i++) begin
      if (alloc_hit && alloc_tag == tag_t'(i)) busy_next[i] = 1'b1;
      if (free && free_tag == tag_t'(i))       busy_next[i] = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      busy       <= '0;
      busy_count <= '0;
    end else begin
      busy       <= busy_next;
      busy_count <= busy_count + 9'(alloc_hit) - 9'(free);
    end
  end

endmodule

// File: rtl/capi_command_arbiter.sv
// rtl/capi_command_arbiter.sv - round-robin PSL command arbiter with credits, tags and response routing
// Optional: CAPI_RSP_PARITY_CHECK_EN adds response tag parity checking and rsp_parity_err.
module capi_command_arbiter
  import capi_command_arbiter_pkg::*;
#(
  parameter int NUM_REQ  = 4,
  parameter int NUM_TAGS = 32
) (
  input  logic                        clock,
  input  logic                        reset_n,
  input  logic                        job_start,
  input  CommandInterfaceInput        croom_in,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ-1:0][12:0]    req_command,
  input  logic [NUM_REQ-1:0][63:0]    req_address,
  input  logic [NUM_REQ-1:0][11:0]    req_size,
  output logic [NUM_REQ-1:0]          req_ready,
  input  logic [15:0]                 ctx_handle,
  output CommandInterfaceOutput       cmd_out,
  input  ResponseInterface            rsp_in,
  output logic [NUM_REQ-1:0]          rsp_valid,
  output logic [7:0]                  rsp_code,
  output tag_t                        rsp_tag,
  output logic [7:0]                  credits,
  output logic [8:0]                  tags_busy
`ifdef CAPI_RSP_PARITY_CHECK_EN
  ,
  output logic                        rsp_parity_err
`endif
);

  localparam int OW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int TW = (NUM_TAGS > 1) ? $clog2(NUM_TAGS) : 1;

  logic [OW-1:0]       rr_ptr;
  logic [OW-1:0]       winner;
  logic                found;
  int                  idx;
  logic                any_free;
  tag_t                alloc_tag;
  logic [NUM_TAGS-1:0] tag_busy;
  logic [255:0]        busy_full;
  logic                eligible;
  logic                accept;
  logic                rsp_hit;
  logic [OW-1:0]       owner [NUM_TAGS];
  logic signed [9:0]   rsp_delta;
  logic signed [9:0]   cred_sum;
  logic [7:0]          cred_next;

  capi_tag_pool #(.NUM_TAGS(NUM_TAGS)) u_tag_pool (
    .clock      (clock),
    .reset_n    (reset_n),
    .alloc      (accept),
    .free       (rsp_hit),
    .free_tag   (rsp_in.tag),
    .any_free   (any_free),
    .alloc_tag  (alloc_tag),
    .busy       (tag_busy),
    .busy_count (tags_busy)
  );

  assign busy_full = 256'(tag_busy);

  always_comb begin
    found  = 1'b0;
    winner = '0;
    idx    = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = (int'(rr_ptr) + i) % NUM_REQ;
      if (!found && req_valid[idx]) begin
        found  = 1'b1;
        winner = OW'(idx);
      end
    end
  end

  assign eligible = (credits != 8'd0) && any_free && !job_start;
  assign accept   = eligible && found;

  always_comb begin
    req_ready = '0;
    if (accept) req_ready[winner] = 1'b1;
  end

`ifdef CAPI_RSP_PARITY_CHECK_EN
  logic rsp_par_ok;
  assign rsp_par_ok = (rsp_in.tag_parity == odd_parity(64'(rsp_in.tag)));
  assign rsp_hit    = rsp_in.valid && busy_full[rsp_in.tag] && rsp_par_ok;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)                        rsp_parity_err <= 1'b0;
    else if (rsp_in.valid && !rsp_par_ok) rsp_parity_err <= 1'b1;
  end
`else
  logic unused_tag_parity;
  assign unused_tag_parity = rsp_in.tag_parity;
  assign rsp_hit           = rsp_in.valid && busy_full[rsp_in.tag];
`endif

  // Response credits are a signed 9-bit delta; the sum is clamped into the 8-bit counter range.
  always_comb begin
    rsp_delta = rsp_in.valid ? $signed({rsp_in.credits[8], rsp_in.credits}) : 10'sd0;
    cred_sum  = $signed({2'b00, credits}) + rsp_delta - $signed({9'd0, accept});
    if (cred_sum < 10'sd0)        cred_next = 8'd0;
    else if (cred_sum > 10'sd255) cred_next = 8'd255;
    else                          cred_next = cred_sum[7:0];
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      credits   <= '0;
      rr_ptr    <= '0;
      cmd_out   <= '0;
      rsp_valid <= '0;
      rsp_code  <= '0;
      rsp_tag   <= '0;
      for (int t = 0; t < NUM_TAGS; t++) owner[t] <= '0;
    end else begin
      credits       <= job_start ? croom_in.room : cred_next;
      cmd_out.valid <= accept;
      if (accept) begin
        rr_ptr                     <= (winner == OW'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
        owner[alloc_tag[TW-1:0]]   <= winner;
        cmd_out.command            <= req_command[winner];
        cmd_out.command_parity     <= odd_parity(64'(req_command[winner]));
        cmd_out.tag                <= alloc_tag;
        cmd_out.tag_parity         <= odd_parity(64'(alloc_tag));
        cmd_out.abt                <= 3'b000;
        cmd_out.address            <= req_address[winner];
        cmd_out.address_parity     <= odd_parity(req_address[winner]);
        cmd_out.context_handle     <= ctx_handle;
        cmd_out.size               <= req_size[winner];
      end
      rsp_valid <= '0;
      if (rsp_hit) begin
        rsp_valid[owner[rsp_in.tag[TW-1:0]]] <= 1'b1;
        rsp_code                             <= rsp_in.response;
        rsp_tag                              <= rsp_in.tag;
      end
    end
  end

endmodule

// File: tb/tb_capi_command_arbiter.sv
// tb/tb_capi_command_arbiter.sv - randomized bench with behavioural model for capi_command_arbiter
`timescale 1ns/1ps
module tb_capi_command_arbiter;
  import capi_command_arbiter_pkg::*;

  localparam int NR = 4;
  localparam int NT = 32;

  logic                  clock = 1'b0;
  logic                  reset_n = 1'b0;
  logic                  job_start = 1'b0;
  CommandInterfaceInput  croom_in;
  logic [NR-1:0]         req_valid;
  logic [NR-1:0][12:0]   req_command;
  logic [NR-1:0][63:0]   req_address;
  logic [NR-1:0][11:0]   req_size;
  logic [NR-1:0]         req_ready;
  logic [15:0]           ctx_handle;
  CommandInterfaceOutput cmd_out;
  ResponseInterface      rsp_in;
  logic [NR-1:0]         rsp_valid;
  logic [7:0]            rsp_code;
  tag_t                  rsp_tag;
  logic [7:0]            credits;
  logic [8:0]            tags_busy;
`ifdef CAPI_RSP_PARITY_CHECK_EN
  logic                  rsp_parity_err;
`endif

  capi_command_arbiter #(.NUM_REQ(NR), .NUM_TAGS(NT)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .job_start   (job_start),
    .croom_in    (croom_in),
    .req_valid   (req_valid),
    .req_command (req_command),
    .req_address (req_address),
    .req_size    (req_size),
    .req_ready   (req_ready),
    .ctx_handle  (ctx_handle),
    .cmd_out     (cmd_out),
    .rsp_in      (rsp_in),
    .rsp_valid   (rsp_valid),
    .rsp_code    (rsp_code),
    .rsp_tag     (rsp_tag),
    .credits     (credits),
    .tags_busy   (tags_busy)
`ifdef CAPI_RSP_PARITY_CHECK_EN
    ,
    .rsp_parity_err (rsp_parity_err)
`endif
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic par_of(input logic [63:0] v);
    return ($countones(v) % 2) == 0;
  endfunction

  // Behavioural model: credit integer, busy/owner arrays, RR index.
  int            m_credits;
  bit            m_busy [NT];
  int            m_owner [NT];
  int            m_rr;
  bit            e_perr;
  bit            e_cvalid;
  int            e_ctag;
  logic [12:0]   e_ccmd;
  logic [63:0]   e_caddr;
  logic [11:0]   e_csize;
  logic [15:0]   e_cctx;
  logic [NR-1:0] e_rvalid;
  logic [7:0]    e_rcode;
  logic [7:0]    e_rtag;

  int obs_tag[$];
  int obs_cmd[$];
  int obs_apar[$];
  int obs_tpar[$];
  int obs_rsp[$];

  always @(negedge clock) begin
    int nbusy, win, atag, sum, rt;
    logic [NR-1:0] e_ready;
    bit anyfree, pok;
    if (!reset_n) begin
      m_credits = 0; m_rr = 0; e_perr = 0;
      for (int t = 0; t < NT; t++) begin m_busy[t] = 0; m_owner[t] = 0; end
      e_cvalid = 0; e_ctag = 0; e_ccmd = '0; e_caddr = '0; e_csize = '0; e_cctx = '0;
      e_rvalid = '0; e_rcode = '0; e_rtag = '0;
    end
    if (cmd_out.valid) begin
      obs_tag.push_back(int'(cmd_out.tag));
      obs_cmd.push_back(int'(cmd_out.command));
      obs_apar.push_back(int'(cmd_out.address_parity));
      obs_tpar.push_back(int'(cmd_out.tag_parity));
    end
    if (rsp_valid != '0) obs_rsp.push_back(int'(rsp_valid));

    nbusy = 0; anyfree = 0;
    for (int t = 0; t < NT; t++) begin
      if (m_busy[t]) nbusy++; else anyfree = 1;
    end
    check("credits", credits, m_credits);
    check("tags_busy", tags_busy, nbusy);
    check("cmd_valid", cmd_out.valid, e_cvalid);
    if (e_cvalid) begin
      check("cmd_tag", cmd_out.tag, e_ctag);
      check("cmd_tag_par", cmd_out.tag_parity, par_of(64'(e_ctag)));
      check("cmd_command", cmd_out.command, e_ccmd);
      check("cmd_cmd_par", cmd_out.command_parity, par_of(64'(e_ccmd)));
      check("cmd_address", cmd_out.address, e_caddr);
      check("cmd_addr_par", cmd_out.address_parity, par_of(e_caddr));
      check("cmd_size", cmd_out.size, e_csize);
      check("cmd_ctx", cmd_out.context_handle, e_cctx);
      check("cmd_abt", cmd_out.abt, 0);
    end
    check("rsp_valid", rsp_valid, e_rvalid);
    if (e_rvalid != '0) begin
      check("rsp_code", rsp_code, e_rcode);
      check("rsp_tag", rsp_tag, e_rtag);
    end
`ifdef CAPI_RSP_PARITY_CHECK_EN
    check("rsp_parity_err", rsp_parity_err, e_perr);
`endif

    win = -1;
    if (reset_n && m_credits > 0 && anyfree && !job_start) begin
      for (int k = 0; k < NR; k++) begin
        if (win < 0 && req_valid[(m_rr + k) % NR]) win = (m_rr + k) % NR;
      end
    end
    e_ready = '0;
    if (win >= 0) e_ready[win] = 1'b1;
    check("req_ready", req_ready, e_ready);

    if (reset_n) begin
      atag = -1;
      for (int t = NT - 1; t >= 0; t--) if (!m_busy[t]) atag = t;
      e_rvalid = '0;
      if (rsp_in.valid) begin
        rt  = int'(rsp_in.tag);
        pok = 1;
`ifdef CAPI_RSP_PARITY_CHECK_EN
        pok = (rsp_in.tag_parity == par_of(64'(rsp_in.tag)));
        if (!pok) e_perr = 1;
`endif
        if (pok && rt < NT && m_busy[rt]) begin
          e_rvalid[m_owner[rt]] = 1'b1;
          e_rcode = rsp_in.response;
          e_rtag  = rsp_in.tag;
          m_busy[rt] = 0;
        end
      end
      e_cvalid = (win >= 0);
      if (win >= 0) begin
        e_ctag  = atag;
        e_ccmd  = req_command[win];
        e_caddr = req_address[win];
        e_csize = req_size[win];
        e_cctx  = ctx_handle;
        m_busy[atag]  = 1;
        m_owner[atag] = win;
        m_rr = (win + 1) % NR;
      end
      sum = m_credits - ((win >= 0) ? 1 : 0);
      if (rsp_in.valid) sum = sum + int'(rsp_in.credits) - (rsp_in.credits[8] ? 512 : 0);
      if (sum < 0) sum = 0;
      if (sum > 255) sum = 255;
      m_credits = job_start ? int'(croom_in.room) : sum;
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
    job_start    = 1'b0;
    rsp_in.valid = 1'b0;
  endtask

  task automatic set_rsp(input int tag, input int cr, input logic [7:0] code, input bit bad_par);
    rsp_in.valid      = 1'b1;
    rsp_in.tag        = tag_t'(tag);
    rsp_in.tag_parity = par_of(64'(tag)) ^ bad_par;
    rsp_in.credits    = 9'(cr);
    rsp_in.response   = code;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  int sel_list[$];

  initial begin
    croom_in = '0; req_valid = '0; req_command = '0; req_address = '0; req_size = '0;
    ctx_handle = 16'hBEEF; rsp_in = '0;
    tick(); tick();
    check("reset_credits", credits, 0);
    check("reset_cmd_valid", cmd_out.valid, 0);
    check("reset_tags_busy", tags_busy, 0);
    reset_n = 1'b1;
    tick();

    // Room of 4: req0 issues tags 0..3 back to back, fifth stalls.
    croom_in.room = 8'd4; job_start = 1'b1;
    tick();
    obs_tag.delete(); obs_apar.delete(); obs_tpar.delete();
    req_valid = 4'b0001; req_command[0] = PSL_CMD_READ_CL_NA;
    req_address[0] = 64'h0000_0000_0000_0001; req_size[0] = 12'd128;
    repeat (7) tick();
    check("t1_count", obs_tag.size(), 4);
    for (int i = 0; i < 4 && i < obs_tag.size(); i++) check("t1_tag", obs_tag[i], i);
    if (obs_apar.size() > 0) check("t1_addr_par", obs_apar[0], 0);
    if (obs_tpar.size() > 3) check("t1_tag3_par", obs_tpar[3], 1);
    check("t1_credits", credits, 0);
    check("t1_ready", req_ready, 0);

    // Retire tag 1 with one credit: strobe to req0, tag 1 reused.
    obs_tag.delete(); obs_rsp.delete();
    set_rsp(1, 1, 8'h00, 1'b0);
    repeat (4) tick();
    check("t2_rsp_count", obs_rsp.size(), 1);
    if (obs_rsp.size() > 0) check("t2_rsp_onehot", obs_rsp[0], 1);
    check("t2_cmd_count", obs_tag.size(), 1);
    if (obs_tag.size() > 0) check("t2_reused_tag", obs_tag[0], 1);

    // Response to idle tag 7: no strobe, credits +2.
    req_valid = '0;
    tick();
    obs_rsp.delete();
    set_rsp(7, 2, 8'h0A, 1'b0);
    tick(); tick();
    check("t3_credits", credits, 2);
    check("t3_no_rsp", obs_rsp.size(), 0);

    // All four requesting: grant order 0,1,2,3,0 at one command per cycle.
    do_reset();
    croom_in.room = 8'd200; job_start = 1'b1;
    tick();
    for (int i = 0; i < NR; i++) req_command[i] = 13'(16 + i);
    obs_cmd.delete();
    req_valid = '1;
    repeat (5) tick();
    req_valid = '0;
    repeat (2) tick();
    check("t4_count", obs_cmd.size(), 5);
    for (int i = 0; i < 5 && i < obs_cmd.size(); i++) check("t4_order", obs_cmd[i], 16 + (i % NR));

    // Reset with tags outstanding: late response is dropped, credits still applied.
    do_reset();
    obs_rsp.delete();
    set_rsp(0, 3, 8'h01, 1'b0);
    tick(); tick();
    check("t5_no_rsp", obs_rsp.size(), 0);
    check("t5_credits", credits, 3);

    // Clamp at both ends of the credit range.
    croom_in.room = 8'd250; job_start = 1'b1;
    tick();
    set_rsp(9, 100, 8'h00, 1'b0);
    tick(); tick();
    check("clamp_hi", credits, 255);
    set_rsp(9, -256, 8'h00, 1'b0);
    tick(); tick();
    check("clamp_lo", credits, 0);

`ifdef CAPI_RSP_PARITY_CHECK_EN
    croom_in.room = 8'd10; job_start = 1'b1;
    tick();
    req_valid = 4'b0001;
    tick();
    req_valid = '0;
    tick();
    obs_rsp.delete();
    set_rsp(0, 1, 8'h00, 1'b1);
    tick(); tick();
    check("par_dropped", obs_rsp.size(), 0);
    check("par_err_set", rsp_parity_err, 1);
    tick();
    check("par_err_sticky", rsp_parity_err, 1);
    do_reset();
    check("par_err_clear", rsp_parity_err, 0);
`endif

    // Randomized traffic.
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if ($urandom_range(0, 499) == 0) begin
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
      end
      req_valid = NR'($urandom);
      for (int i = 0; i < NR; i++) begin
        req_command[i] = 13'($urandom);
        req_address[i] = {$urandom, $urandom};
        req_size[i]    = 12'($urandom);
      end
      ctx_handle = 16'($urandom);
      if ($urandom_range(0, 60) == 0) begin
        job_start = 1'b1;
        croom_in.room = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 6));
      end
      if ($urandom_range(0, 2) == 0) begin
        int tg, cr;
        sel_list.delete();
        for (int t = 0; t < NT; t++) if (m_busy[t]) sel_list.push_back(t);
        if (sel_list.size() > 0 && $urandom_range(0, 4) != 0)
          tg = sel_list[$urandom_range(0, sel_list.size() - 1)];
        else
          tg = $urandom_range(0, 63);
        case ($urandom_range(0, 19))
          0:       cr = -256;
          1:       cr = 255;
          2:       cr = -$urandom_range(1, 3);
          default: cr = $urandom_range(0, 3);
        endcase
        set_rsp(tg, cr, 8'($urandom), 1'b0);
      end
      tick();
    end
    req_valid = '0;
    tick(); tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
